tan_job_sequencer: RTL and testbench

Upstream feeder for the tan unit (controller plus datapath). It buffers incoming 16-bit x operands in a small FIFO and launches one tan computation per operand using the unit's start/done protocol. Each result is captured into a single-entry valid/ready output slot. It also keeps a completed-job count and a sticky timeout error for system status.

---
 rtl/tan_pkg.sv | 23 ++
 rtl/tan_fifo.sv | 58 +++++
 rtl/tan_job_sequencer.sv | 150 +++++++++++++++
 tb/tb_tan_job_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tan_pkg.sv
// tan_pkg: shared definitions for the tan unit feeder.
//   - TAN_W / TAN_TIMEOUT : default operand width and job timeout
//   - START_ASSERT / DONE_IDLE : tan controller handshake polarities
//   - state_t : job sequencer FSM states
package tan_pkg;

  localparam int TAN_W       = 16;
  localparam int TAN_TIMEOUT = 255;

  // The controller samples start active-high; done sits high while the
  // controller is idle and drops once it has accepted a job.
  localparam logic START_ASSERT = 1'b1;
  localparam logic DONE_IDLE    = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START_HI,
    START_LO,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

endpackage

// File: rtl/tan_fifo.sv
// tan_fifo: synchronous DEPTH x W operand FIFO with first-word fall-through
// head (the head entry is visible whenever empty is low).
// Ports:
//   clk, reset     clock, synchronous active-high reset (pointers only)
//   push/push_data write request; ignored while full
//   pop            read request; ignored while empty
//   head           current head entry
//   full, empty    occupancy flags
module tan_fifo
  import tan_pkg::*;
#(
  parameter int W     = TAN_W,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  // One extra pointer bit separates the full case from the empty case.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are meaningful, and an unreset array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/tan_job_sequencer.sv
// tan_job_sequencer: feeds buffered x operands to the tan unit one job at a
// time over its start/done handshake and parks each result in a one-entry
// valid/ready slot.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   in_valid/in_data/in_ready operand input (in_ready = FIFO not full)
//   out_valid/out_data/out_ready result slot
//   tan_start, tan_x          start pulse and operand to the tan unit
//   tan_done, tan_result      done (high while idle) and result from tan unit
//   busy                      a job is in flight
//   err_timeout               sticky, set when a job is abandoned
//   jobs_done                 wrapping count of captured results
module tan_job_sequencer
  import tan_pkg::*;
#(
  parameter int W       = TAN_W,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = TAN_TIMEOUT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         tan_start,
  output logic [W-1:0] tan_x,
  input  logic         tan_done,
  input  logic [W-1:0] tan_result,
  output logic         busy,
  output logic         err_timeout,
  output logic [7:0]   jobs_done
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state;
  state_t        state_next;
  logic          pop;
  logic          capture;
  logic          cnt_run;
  logic          tmo_hit;
  logic          slot_free;
  logic          full;
  logic          empty;
  logic [W-1:0]  head;
  logic [CW-1:0] tmo_cnt;
  logic          tmo_last;

  tan_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign in_ready  = !full;
  assign tan_start = (state == START_HI) ? START_ASSERT : !START_ASSERT;
  assign busy      = (state != IDLE);
  // A result may land in the slot if it is empty or being drained this cycle.
  assign slot_free = !out_valid || out_ready;
  // This cycle's increment would make the counter reach TIMEOUT.
  assign tmo_last  = (tmo_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    capture    = 1'b0;
    cnt_run    = 1'b0;
    tmo_hit    = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = START_HI;
        end
      end
      START_HI: state_next = START_LO;
      START_LO: begin
        cnt_run    = 1'b1;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        cnt_run = 1'b1;
        if (tan_done != DONE_IDLE) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tan_done == DONE_IDLE) begin
          // With the slot full we simply hold: the tan unit keeps its
          // result while idle, and the timeout is frozen.
          if (slot_free) begin
            capture    = 1'b1;
            state_next = IDLE;
          end
        end else begin
          cnt_run = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    // A completed result always wins; cnt_run is low on the capture path.
    if (cnt_run && tmo_last) begin
      tmo_hit    = 1'b1;
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt     <= '0;
      tan_x       <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      err_timeout <= 1'b0;
      jobs_done   <= '0;
    end else begin
      if (pop)          tmo_cnt <= '0;
      else if (cnt_run) tmo_cnt <= tmo_cnt + CW'(1);

      if (pop) tan_x <= head;

      if (capture) begin
        out_valid <= 1'b1;
        out_data  <= tan_result;
        jobs_done <= jobs_done + 8'd1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (tmo_hit) err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tan_job_sequencer.sv
// Self-checking bench for tan_job_sequencer. A behavioural tan unit answers
// each start pulse with done low for a fixed latency, then x + 0x0234.
module tb_tan_job_sequencer;

  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int TMO   = 20;
  localparam int LAT   = 12;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         tan_start;
  logic [W-1:0] tan_x;
  logic         tan_done = 1'b1;
  logic [W-1:0] tan_result = '0;
  logic         busy;
  logic         err_timeout;
  logic [7:0]   jobs_done;

  tan_job_sequencer #(
    .W       (W),
    .DEPTH   (DEPTH),
    .TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .tan_start   (tan_start),
    .tan_x       (tan_x),
    .tan_done    (tan_done),
    .tan_result  (tan_result),
    .busy        (busy),
    .err_timeout (err_timeout),
    .jobs_done   (jobs_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] res;
  } vec_t;

  int           total = 0;
  int           bad   = 0;
  int           started = 0;
  logic         prev_start = 1'b0;
  bit           hang = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] x_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: event not expected or bound expired", name);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [W-1:0] x, input logic [W-1:0] res, input bit has_res);
    int n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) fail("push_wait");
    in_valid = 1'b1;
    in_data  = x;
    tick();
    in_valid = 1'b0;
    x_q.push_back(x);
    if (has_res) exp_q.push_back(res);
  endtask

  task automatic wait_out_valid(input string name);
    int n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    check(name, out_valid, 1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy || out_valid) && n < 500) begin
      tick();
      n++;
    end
    check(name, (n < 500), 1);
  endtask

  // Behavioural tan unit: start rises, falls, then done low for lat cycles.
  logic [W-1:0] m_x = '0;
  bit           m_pend = 1'b0;
  int           m_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (reset) begin
      tan_done = 1'b1;
      m_pend   = 1'b0;
      m_cnt    = 0;
    end else if (tan_start) begin
      m_pend = 1'b1;
      m_x    = tan_x;
    end else if (m_pend) begin
      m_pend   = 1'b0;
      tan_done = 1'b0;
      m_cnt    = LAT;
    end else if (!tan_done && m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0 && !hang) begin
        tan_done   = 1'b1;
        tan_result = m_x + 16'h0234;
      end
    end
  end

  // Scoreboard side: start pulses and slot transfers checked mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (tan_start) begin
        started++;
        check("start_one_cycle", prev_start, 0);
        if (x_q.size() == 0) fail("start_unexpected");
        else check("start_tan_x", tan_x, x_q.pop_front());
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail("out_unexpected");
        else check("out_data", out_data, exp_q.pop_front());
      end
    end
    prev_start = tan_start;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   s0;
    vecs[0] = '{16'h0100, 16'h0334};
    vecs[1] = '{16'h0200, 16'h0434};
    vecs[2] = '{16'h0300, 16'h0534};
    vecs[3] = '{16'hFFFF, 16'h0233};
    vecs[4] = '{16'h8000, 16'h8234};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    tick(2);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_tan_start", tan_start, 0);
    check("rst_tan_x", tan_x, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_timeout, 0);
    check("rst_jobs", jobs_done, 0);
    reset = 1'b0;
    tick();

    // Single job with exact start timing.
    push(16'h1000, 16'h1234, 1'b1);
    check("single_no_start_yet", tan_start, 0);
    tick();
    check("single_start_hi", tan_start, 1);
    check("single_tan_x", tan_x, 16'h1000);
    check("single_busy", busy, 1);
    tick();
    check("single_start_lo", tan_start, 0);
    check("single_tan_x_hold", tan_x, 16'h1000);
    wait_out_valid("single_out_valid");
    check("single_out_data", out_data, 16'h1234);
    check("single_jobs", jobs_done, 1);
    drain("single_drain");
    check("single_starts", started, 1);

    // Back-to-back burst from the vector table.
    s0 = started;
    for (int i = 0; i < 5; i++) begin
      check("burst_in_ready", in_ready, 1);
      push(vecs[i].x, vecs[i].res, 1'b1);
    end
    drain("burst_drain");
    check("burst_starts", started - s0, 5);
    check("burst_jobs", jobs_done, 6);

    // Backpressure: second result waits in WAIT_DONE without timing out.
    out_ready = 1'b0;
    push(16'h0400, 16'h0634, 1'b1);
    push(16'h0500, 16'h0734, 1'b1);
    wait_out_valid("bp_first_valid");
    check("bp_first_data", out_data, 16'h0634);
    check("bp_jobs_1", jobs_done, 7);
    tick(25);
    check("bp_hold_busy", busy, 1);
    check("bp_hold_data", out_data, 16'h0634);
    tick(30);
    check("bp_no_timeout", err_timeout, 0);
    check("bp_still_busy", busy, 1);
    check("bp_jobs_held", jobs_done, 7);
    out_ready = 1'b1;
    tick();
    check("bp_second_valid", out_valid, 1);
    check("bp_second_data", out_data, 16'h0734);
    check("bp_jobs_2", jobs_done, 8);
    check("bp_idle", busy, 0);
    drain("bp_drain");

    // FIFO full: stall the sequencer, fill all four entries, offer a fifth.
    out_ready = 1'b0;
    push(16'h0600, 16'h0834, 1'b1);
    push(16'h0700, 16'h0934, 1'b1);
    wait_out_valid("full_p0_valid");
    tick(25);
    push(16'h0010, 16'h0244, 1'b1);
    push(16'h0020, 16'h0254, 1'b1);
    push(16'h0030, 16'h0264, 1'b1);
    push(16'h0040, 16'h0274, 1'b1);
    check("full_in_ready_low", in_ready, 0);
    in_valid = 1'b1;
    in_data  = 16'h0050;
    for (int i = 0; i < 5; i++) begin
      check("full_fifth_blocked", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    begin
      int n = 0;
      while (!in_ready && n < 100) begin
        tick();
        n++;
      end
      check("full_space_after_pop", in_ready, 1);
    end
    tick();
    in_valid = 1'b0;
    x_q.push_back(16'h0050);
    exp_q.push_back(16'h0284);
    drain("full_drain");
    check("full_jobs", jobs_done, 15);

    // Timeout: the tan unit never returns done.
    hang = 1'b1;
    push(16'h0900, 16'h0000, 1'b0);
    begin
      int n = 0;
      while (!tan_start && n < 20) begin
        tick();
        n++;
      end
      check("tmo_start_seen", tan_start, 1);
    end
    tick(TMO);
    check("tmo_not_yet", err_timeout, 0);
    check("tmo_busy_before", busy, 1);
    tick();
    check("tmo_err", err_timeout, 1);
    check("tmo_idle", busy, 0);
    check("tmo_no_out", out_valid, 0);
    check("tmo_jobs_same", jobs_done, 15);
    hang = 1'b0;
    push(16'h0A00, 16'h0C34, 1'b1);
    drain("tmo_next_drain");
    check("tmo_next_jobs", jobs_done, 16);
    check("tmo_err_sticky", err_timeout, 1);

    // Reset while stalled in WAIT_DONE with two operands queued.
    out_ready = 1'b0;
    push(16'h0B00, 16'h0D34, 1'b1);
    push(16'h0C00, 16'h0E34, 1'b1);
    wait_out_valid("rstmid_first_valid");
    tick(25);
    push(16'h0D00, 16'h0F34, 1'b1);
    push(16'h0E00, 16'h1034, 1'b1);
    check("rstmid_pre_busy", busy, 1);
    reset = 1'b1;
    tick();
    check("rstmid_out_valid", out_valid, 0);
    check("rstmid_out_data", out_data, 0);
    check("rstmid_tan_start", tan_start, 0);
    check("rstmid_tan_x", tan_x, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_err", err_timeout, 0);
    check("rstmid_jobs", jobs_done, 0);
    check("rstmid_in_ready", in_ready, 1);
    tick();
    exp_q.delete();
    x_q.delete();
    reset = 1'b0;
    s0 = started;
    tick(10);
    check("rstmid_no_start", started - s0, 0);
    check("rstmid_still_idle", busy, 0);
    out_ready = 1'b1;
    push(16'h0001, 16'h0235, 1'b1);
    drain("rstmid_after_drain");
    check("rstmid_after_jobs", jobs_done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
